riscv_imem_port_arbiter: RTL and testbench



---
 rtl/riscv_imem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_riscv_imem_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_imem_port_arbiter.sv
// riscv_imem_port_arbiter: round-robin share of one I-mem port among NUM_REQ fetchers, in-order owner tags route rvalid back.
// Latency: zero-cycle combinational request/grant and rvalid/rdata forwarding; returns are matched to grants strictly in order.
// Backpressure: no mem_req while the tag FIFO is full; a stalled request locks its address until granted or dropped. IMEM_ARB_PERF_CNT_EN adds perf counters.
module riscv_imem_port_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int RDATA_WIDTH = 128,
    parameter int OUTST_L2    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0][31:0] addr_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       rvalid_o,
    output logic [RDATA_WIDTH-1:0]   rdata_o,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic [RDATA_WIDTH-1:0]   mem_rdata_i,
    output logic                     busy_o,
`ifdef IMEM_ARB_PERF_CNT_EN
    output logic [NUM_REQ-1:0][15:0] perf_gnt_cnt_o,
    output logic [15:0]              perf_stall_cnt_o,
`endif
    output logic                     err_o
);
    localparam int IDW   = $clog2(NUM_REQ);
    localparam int DEPTH = 1 << OUTST_L2;
    localparam logic [OUTST_L2:0] FULL_CNT = DEPTH[OUTST_L2:0];
    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]          state;
    logic [IDW-1:0]      rr_ptr, lock_id, rr_sel, sel, head;
    logic                rr_vld, sel_vld, use_lock, full, empty, hs, pop;
    logic [IDW-1:0]      tag_mem [DEPTH];
    logic [OUTST_L2-1:0] wr_ptr, rd_ptr;
    logic [OUTST_L2:0]   count;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    // Walk downward so the lowest offset from rr_ptr wins.
    always_comb begin
        rr_sel = rr_ptr;
        rr_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[wrap_idx(rr_ptr, i)]) begin
                rr_sel = wrap_idx(rr_ptr, i);
                rr_vld = 1'b1;
            end
        end
    end

    // A dropped locked request falls back to round-robin in the same cycle.
    assign use_lock   = (state == HOLD) && req_i[lock_id];
    assign sel        = use_lock ? lock_id : rr_sel;
    assign sel_vld    = use_lock || rr_vld;
    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign mem_req_o  = sel_vld && !full;
    assign mem_addr_o = addr_i[sel] & 32'hFFFF_FFF0;
    assign hs         = mem_req_o && mem_gnt_i;
    assign pop        = mem_rvalid_i && !empty;
    assign head       = tag_mem[rd_ptr];
    assign rdata_o    = mem_rdata_i;
    assign busy_o     = !empty || mem_req_o;

    always_comb begin
        gnt_o         = '0;
        rvalid_o      = '0;
        gnt_o[sel]    = hs;
        rvalid_o[head] = pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB;
            rr_ptr  <= '0;
            lock_id <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_o   <= 1'b0;
        end else begin
            if (!full) begin
                if (hs) begin
                    state  <= ARB;
                    rr_ptr <= wrap_idx(sel, 1);
                end else if (mem_req_o) begin
                    state   <= HOLD;
                    lock_id <= sel;
                end else begin
                    state <= ARB;
                end
            end
            if (hs)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (hs && !pop)      count <= count + 1'b1;
            else if (pop && !hs) count <= count - 1'b1;
            if (mem_rvalid_i && empty) err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (hs) tag_mem[wr_ptr] <= sel;
    end

`ifdef IMEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_gnt_cnt_o   <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (hs && perf_gnt_cnt_o[sel] != 16'hFFFF)
                perf_gnt_cnt_o[sel] <= perf_gnt_cnt_o[sel] + 16'd1;
            if ((|req_i) && !hs && perf_stall_cnt_o != 16'hFFFF)
                perf_stall_cnt_o <= perf_stall_cnt_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_riscv_imem_port_arbiter.sv
// Bench for riscv_imem_port_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_riscv_imem_port_arbiter;
    localparam int NUM_REQ     = 2;
    localparam int RDATA_WIDTH = 128;
    localparam int OUTST_L2    = 2;
    localparam int DEPTH       = 1 << OUTST_L2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_i = '0;
    logic [NUM_REQ-1:0][31:0] addr_i;
    logic [NUM_REQ-1:0]       gnt_o, rvalid_o;
    logic [RDATA_WIDTH-1:0]   rdata_o;
    logic                     mem_req_o;
    logic [31:0]              mem_addr_o;
    logic                     mem_gnt_i = 1'b0;
    logic                     mem_rvalid_i = 1'b0;
    logic [RDATA_WIDTH-1:0]   mem_rdata_i = '0;
    logic                     busy_o, err_o;
`ifdef IMEM_ARB_PERF_CNT_EN
    logic [NUM_REQ-1:0][15:0] perf_gnt_cnt_o;
    logic [15:0]              perf_stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: owner queue, round-robin pointer, locked requester (-1 = none).
    int q[$];
    int rr_m;
    int lock_m;
    bit err_m;
    int gcnt_m[NUM_REQ];
    int stall_m;
    logic [NUM_REQ-1:0] last_gnt_m;

    always #5 clk = ~clk;

    riscv_imem_port_arbiter #(
        .NUM_REQ(NUM_REQ), .RDATA_WIDTH(RDATA_WIDTH), .OUTST_L2(OUTST_L2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o),
`ifdef IMEM_ARB_PERF_CNT_EN
        .perf_gnt_cnt_o(perf_gnt_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
        .err_o(err_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int cand;
        bit full, mreq, hs, pop;
        logic [NUM_REQ-1:0] eg, erv;
        full = (q.size() == DEPTH);
        cand = -1;
        if (lock_m >= 0 && req_i[lock_m]) cand = lock_m;
        else
            for (int i = 0; i < NUM_REQ; i++)
                if (cand < 0 && req_i[(rr_m + i) % NUM_REQ]) cand = (rr_m + i) % NUM_REQ;
        mreq = (cand >= 0) && !full;
        hs   = mreq && mem_gnt_i;
        pop  = mem_rvalid_i && (q.size() > 0);
        eg  = '0;
        erv = '0;
        if (hs)  eg[cand] = 1'b1;
        if (pop) erv[q[0]] = 1'b1;
        check("gnt", gnt_o, eg);
        check("rvalid", rvalid_o, erv);
        check("mem_req", mem_req_o, mreq);
        check("busy", busy_o, (q.size() > 0) || mreq);
        check("err", err_o, err_m);
        if (cand >= 0) check("mem_addr", mem_addr_o, {addr_i[cand][31:4], 4'h0});
        if (pop) check("rdata", rdata_o, mem_rdata_i);
`ifdef IMEM_ARB_PERF_CNT_EN
        for (int i = 0; i < NUM_REQ; i++) check("perf_gnt", perf_gnt_cnt_o[i], gcnt_m[i]);
        check("perf_stall", perf_stall_cnt_o, stall_m);
`endif
        if (!full) begin
            if (hs) begin
                rr_m   = (cand + 1) % NUM_REQ;
                lock_m = -1;
            end else if (mreq) lock_m = cand;
            else lock_m = -1;
        end
        if (pop) void'(q.pop_front());
        if (hs) q.push_back(cand);
        if (mem_rvalid_i && !pop) err_m = 1'b1;
        if (hs && gcnt_m[cand] < 65535) gcnt_m[cand]++;
        if ((|req_i) && !hs && stall_m < 65535) stall_m++;
        last_gnt_m = eg;
    endtask

    // Addresses only change when a requester starts a new fetch.
    task automatic cycle(input logic [NUM_REQ-1:0] req, input logic gnt, input logic rv);
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++)
            if (!req_i[i] || last_gnt_m[i]) addr_i[i] = $urandom;
        req_i        = req;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        model_step();
    endtask

    task automatic do_reset();
        req_i        = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("rst_gnt", gnt_o, '0);
        check("rst_rvalid", rvalid_o, '0);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        q.delete();
        rr_m       = 0;
        lock_m     = -1;
        err_m      = 1'b0;
        stall_m    = 0;
        last_gnt_m = '0;
        foreach (gcnt_m[i]) gcnt_m[i] = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0]        a0;
        logic [NUM_REQ-1:0] r;
        logic               g, v;
        for (int i = 0; i < NUM_REQ; i++) addr_i[i] = $urandom;
        do_reset();

        // Both requesting, constant grant, returns one cycle later.
        cycle(2'b11, 1'b1, 1'b0);
        check("alt_gnt", gnt_o, 2'b01);
        for (int i = 1; i < 9; i++) begin
            cycle(2'b11, 1'b1, 1'b1);
            check("alt_gnt", gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("alt_rvalid", rvalid_o, (i % 2 == 1) ? 2'b01 : 2'b10);
        end

        // Stalled request keeps its address while requester 1 joins.
        do_reset();
        cycle(2'b01, 1'b0, 1'b0);
        a0 = addr_i[0];
        check("hold_addr", mem_addr_o, {a0[31:4], 4'h0});
        cycle(2'b11, 1'b0, 1'b0);
        check("hold_addr", mem_addr_o, {a0[31:4], 4'h0});
        cycle(2'b11, 1'b0, 1'b0);
        check("hold_addr", mem_addr_o, {a0[31:4], 4'h0});
        cycle(2'b11, 1'b1, 1'b0);
        check("hold_gnt", gnt_o, 2'b01);
        cycle(2'b11, 1'b1, 1'b0);
        check("hold_next_gnt", gnt_o, 2'b10);

        // Tag FIFO full blocks requests, including in the popping cycle.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(2'b01, 1'b1, 1'b0);
            check("fill_gnt", gnt_o, 2'b01);
        end
        cycle(2'b01, 1'b1, 1'b0);
        check("full_req", mem_req_o, 1'b0);
        cycle(2'b01, 1'b1, 1'b1);
        check("full_pop_req", mem_req_o, 1'b0);
        check("full_pop_gnt", gnt_o, 2'b00);
        check("full_pop_rvalid", rvalid_o, 2'b01);
        cycle(2'b01, 1'b1, 1'b0);
        check("after_pop_gnt", gnt_o, 2'b01);

        // Locked request aborted: selection reverts in the same cycle.
        do_reset();
        cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b10, 1'b0, 1'b0);
        check("drop_addr", mem_addr_o, {addr_i[1][31:4], 4'h0});
        cycle(2'b10, 1'b1, 1'b0);
        check("drop_gnt", gnt_o, 2'b10);

        // Return with nothing outstanding.
        do_reset();
        cycle(2'b00, 1'b0, 1'b1);
        check("err_rvalid", rvalid_o, 2'b00);
        cycle(2'b00, 1'b0, 1'b0);
        check("err_set", err_o, 1'b1);
        repeat (3) cycle(2'b11, 1'b1, 1'b0);
        check("err_sticky", err_o, 1'b1);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r = NUM_REQ'($urandom);
            g = ($urandom_range(0, 99) < 55);
            v = (q.size() > 0) && ($urandom_range(0, 99) < 45);
            cycle(r, g, v);
        end

        // Reset with tags outstanding; stale returns flag an error.
        do_reset();
        repeat (3) cycle(2'b01, 1'b1, 1'b0);
        do_reset();
        cycle(2'b00, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b0);
        check("stale_err", err_o, 1'b1);

`ifdef IMEM_ARB_PERF_CNT_EN
        do_reset();
        for (int i = 0; i < 10; i++) cycle(2'b10, 1'b1, (i > 0));
        cycle(2'b00, 1'b0, 1'b1);
        check("perf_gnt10", perf_gnt_cnt_o[1], 16'd10);
        for (int i = 0; i < 65540; i++) cycle(2'b10, 1'b1, (q.size() > 0));
        cycle(2'b00, 1'b0, 1'b1);
        check("perf_sat", perf_gnt_cnt_o[1], 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
